// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB completer memory.
package apb_pkg;

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    // Number of byte lanes in a data word.
    function automatic int unsigned strb_w(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Word index width for a memory of the given depth.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Shift that turns a byte offset into a word index.
    function automatic int unsigned lane_shift(input int unsigned data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 0;
    endfunction

endpackage

// File: rtl/apb_mem_be_ram.sv
// Word-organised RAM with a byte-enable write port and a registered read port.
module apb_mem_be_ram
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic                          rd_clr,
    input  logic [idx_w(MEM_DEPTH)-1:0]   rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          wr_en,
    input  logic [idx_w(MEM_DEPTH)-1:0]   wr_idx,
    input  logic [strb_w(DATA_WIDTH)-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]         wr_data
);

    localparam int unsigned STRB_W = strb_w(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wr_be[k]) begin
                    mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Registered read; rd_clr loads zero so error/abort responses read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clr ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer memory with programmable wait states, byte strobes and
// out-of-range error response.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_CYCLES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic                    wait_ovr_en,
    input  logic [WAIT_W-1:0]       wait_ovr
);

    localparam int unsigned STRB_W  = strb_w(DATA_WIDTH);
    localparam int unsigned IDX_W   = idx_w(MEM_DEPTH);
    localparam int unsigned LANE_SH = lane_shift(DATA_WIDTH);

    apb_slv_state_e        state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic                  write_q, err_q, err_d;
    logic [IDX_W-1:0]      idx_q;
    logic [STRB_W-1:0]     strb_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  below_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic                  addr_err;
    logic                  setup;
    logic                  rd_en, rd_clr, wr_en;
    logic                  pready_d, pslverr_d;

    // Address decode of the bus address; the borrow flags addresses below the base.
    always_comb begin
        {below_base, offset} = {1'b0, PADDR} - {1'b0, BASE_ADDR};
        idx_full = offset >> LANE_SH;
        addr_err = below_base || (idx_full >= ADDR_WIDTH'(MEM_DEPTH));
        setup    = (state_q == IDLE) && PSEL && !PENABLE;
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and wait counter; counter only decrements in true access cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = wait_ovr_en ? wait_ovr : WAIT_W'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath strobes and next values of the registered handshake outputs.
    always_comb begin
        rd_en  = 1'b0;
        rd_clr = 1'b0;
        wr_en  = 1'b0;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    rd_en  = !PWRITE || addr_err;
                    rd_clr = addr_err;
                    err_d  = addr_err;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    rd_en  = 1'b1;
                    rd_clr = 1'b1;
                end else if (cnt_q == '0) begin
                    wr_en = write_q && !err_q;
                end
            end
            default: ;
        endcase
        pready_d  = (state_d == ACCESS) && (cnt_d == '0);
        pslverr_d = pready_d && err_d;
    end

    // Counter, transfer capture at setup, and registered PREADY/PSLVERR.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            if (setup) begin
                write_q <= PWRITE;
                err_q   <= addr_err;
                idx_q   <= IDX_W'(idx_full);
                strb_q  <= PSTRB;
                wdata_q <= PWDATA;
            end
        end
    end

    apb_mem_be_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_idx  (IDX_W'(idx_full)),
        .rd_data (PRDATA),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_be   (strb_q),
        .wr_data (wdata_q)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: driver pushes expected responses,
// a monitor pops and compares whenever PREADY is seen.
module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;
    logic        wait_ovr_en;
    logic [7:0]  wait_ovr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          rd;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [256];

    apb_slave_mem dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .wait_ovr_en (wait_ovr_en),
        .wait_ovr    (wait_ovr)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each completed transfer with the head of the scoreboard.
    int acc_waits = 0;
    bit prev_ready = 1'b0;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc_waits  = 0;
            prev_ready = 1'b0;
        end else begin
            if (prev_ready) chk("ready_one_cycle", {63'd0, PREADY}, 64'd0);
            if (!PREADY) begin
                chk("slverr_without_ready", {63'd0, PSLVERR}, 64'd0);
                if (PSEL && PENABLE) acc_waits++;
            end else begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got PREADY=1 expected no pending transfer at %0t", $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("wait_states", 64'(acc_waits), 64'(e.waits));
                    chk("pslverr", {63'd0, PSLVERR}, {63'd0, e.err});
                    if (e.rd || e.err) chk("prdata", {32'd0, PRDATA}, {32'd0, e.rdata});
                end
                acc_waits = 0;
            end
            prev_ready = PREADY;
        end
    end

    task automatic go_idle();
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'($urandom);
        PADDR       = $urandom;
        PWDATA      = $urandom;
        PSTRB       = 4'($urandom);
        wait_ovr_en = 1'($urandom);
        wait_ovr    = 8'($urandom);
    endtask

    // Reference model: word-addressed array, 256 words, base 0, 4-byte words.
    function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input bit oe, input logic [7:0] ov);
        exp_t        e;
        logic [31:0] idx;
        idx     = a / 4;
        e.err   = (idx >= 256);
        e.rd    = !w;
        e.waits = oe ? int'(ov) : 1;
        e.rdata = e.err ? 32'd0 : ref_mem[idx[7:0]];
        if (w && !e.err) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) ref_mem[idx[7:0]][k*8 +: 8] = d[k*8 +: 8];
            end
        end
        return e;
    endfunction

    // One complete transfer followed by 'gap' idle cycles (0 = back-to-back).
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit oe, input logic [7:0] ov, input int gap);
        int n;
        PSEL        = 1'b1;
        PENABLE     = 1'b0;
        PWRITE      = w;
        PADDR       = a;
        PWDATA      = d;
        PSTRB       = s;
        wait_ovr_en = oe;
        wait_ovr    = ov;
        sbq.push_back(model(w, a, d, s, oe, ov));
        @(posedge PCLK); #1;
        PENABLE     = 1'b1;
        wait_ovr_en = 1'($urandom);
        wait_ovr    = 8'($urandom);
        n = 0;
        while (!PREADY && n < 300) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no PREADY expected within 300 cycles at %0t", $time);
        end
        @(posedge PCLK); #1;
        go_idle();
        for (int g = 0; g < gap; g++) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        bit          w, oe;
        logic [7:0]  ov;

        go_idle();
        PRESETn = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_pready", {63'd0, PREADY}, 64'd0);
        chk("reset_pslverr", {63'd0, PSLVERR}, 64'd0);
        chk("reset_prdata", {32'd0, PRDATA}, 64'd0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Give every word a known value through the bus.
        for (int i = 0; i < 256; i++) xfer(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, 8'd0, 0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 8'd0, 1);

        // Default wait state write then read.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'd0, 1);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 8'd0, 1);

        // Zero and three wait states.
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 8'd0, 1);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 8'd3, 1);

        // Partial strobes.
        xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 1'b0, 8'd0, 0);
        xfer(1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0, 8'd0, 0);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 8'd0, 1);
        chk("strobe_merge_model", {32'd0, ref_mem[8]}, {32'd0, 32'hAA22CC44});

        // Out-of-range read and write, then index 0 unchanged.
        xfer(1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 8'd0, 0);
        xfer(1'b1, 32'h400, 32'h1234, 4'hF, 1'b0, 8'd0, 0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0, 1);

        // Override of 5 waits then 0, back-to-back; PSTRB=0 write no change.
        xfer(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 8'd5, 0);
        xfer(1'b0, 32'h28, 32'h0, 4'h0, 1'b1, 8'd0, 0);
        xfer(1'b1, 32'h28, 32'hFFFFFFFF, 4'h0, 1'b1, 8'd0, 0);
        xfer(1'b0, 32'h28, 32'h0, 4'h0, 1'b1, 8'd0, 1);

        // Reset during the second wait cycle of a write; write must be dropped.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8;
        PWDATA = 32'h55; PSTRB = 4'hF; wait_ovr_en = 1'b1; wait_ovr = 8'd4;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("pre_reset_pready", {63'd0, PREADY}, 64'd0);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("midreset_pready", {63'd0, PREADY}, 64'd0);
        chk("midreset_pslverr", {63'd0, PSLVERR}, 64'd0);
        chk("midreset_prdata", {32'd0, PRDATA}, 64'd0);
        go_idle();
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 8'd0, 1);

        // Randomised traffic, including errors and back-to-back transfers.
        for (int t = 0; t < 200; t++) begin
            w  = 1'($urandom);
            oe = 1'($urandom);
            ov = 8'($urandom_range(0, 6));
            s  = 4'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 32'h400 + 32'($urandom_range(0, 4095));
                1:       a = $urandom | 32'h8000_0000;
                default: a = 32'($urandom_range(0, 1023));
            endcase
            xfer(w, a, $urandom, s, oe, ov, $urandom_range(0, 2));
        end

        repeat (4) @(posedge PCLK);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
